window_controller: RTL and testbench
====================================

Name: window_controller

Overview:
- Sequencer for the windowed register file: owns the current window pointer (CWP) and window invalid mask (WIM), and executes SAVE/RESTORE requests.
- On window overflow or underflow, autonomously spills or fills the affected window's 16 locals and ins through a memory handshake before committing the new CWP.
- Sits between the decode/control unit and the register file's CWP, address and RFE inputs.

Parameters:
- NWIN, 4, number of register windows (power of two).
- CWP_W, 2, width of the window pointer (log2 NWIN).
- NSPILL, 16, registers moved per spill/fill (r16..r31).

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  synchronous active-high reset.
- save_req  in  1  request a SAVE (sampled in IDLE only).
- restore_req  in  1  request a RESTORE (sampled in IDLE only).
- wim_we  in  1  load WIM from wim_in (IDLE only).
- wim_in  in  NWIN  new WIM value.
- mem_ack  in  1  memory completed the current transfer.
- cwp  out  CWP_W  current window pointer, drives register file CWP.
- wim  out  NWIN  current window invalid mask.
- busy  out  1  high whenever state is not IDLE.
- rf_win  out  CWP_W  window being spilled or filled.
- rf_addr  out  5  register index being spilled or filled (16 + idx).
- rf_we  out  1  register file write enable (RFE) during fill.
- mem_req  out  1  memory transfer request.
- mem_wr  out  1  1 = spill (store), 0 = fill (load); valid while mem_req is high.
- trap_ovf  out  1  one-cycle pulse on overflow detection.
- trap_unf  out  1  one-cycle pulse on underflow detection.
- done  out  1  one-cycle pulse when CWP commits.

Behaviour:
- Reset values:
  - cwp=0, wim=4'b1000 (bit NWIN-1 set), state=IDLE, idx=0.
  - All pulse, request and enable outputs 0; rf_win=0; rf_addr=0.
- States: IDLE, SPILL, FILL, COMMIT.
- Target window:
  - SAVE: tgt=(cwp-1) mod NWIN.
  - RESTORE: tgt=(cwp+1) mod NWIN.
  - Modulo is by natural CWP_W-bit wrap.
- IDLE arbitration:
  - save_req and restore_req both high: SAVE wins; RESTORE is dropped, not queued.
  - wim_we has lowest priority; it is applied only if no request is taken that cycle.
- IDLE, request taken, wim[tgt]=0: go to COMMIT.
- IDLE, SAVE taken, wim[tgt]=1: go to SPILL; trap_ovf=1 for that transition cycle; idx=0; rf_win=tgt.
- IDLE, RESTORE taken, wim[tgt]=1: go to FILL; trap_unf=1; idx=0; rf_win=tgt.
- SPILL:
  - mem_req=1, mem_wr=1, rf_addr=16+idx.
  - mem_req holds until mem_ack.
  - On mem_ack: idx increments; at idx=NSPILL-1 the next state is COMMIT.
- FILL:
  - mem_req=1, mem_wr=0, rf_addr=16+idx.
  - rf_we is asserted combinationally in the mem_ack cycle only.
  - Same idx and exit rules as SPILL.
- mem_ack outside SPILL/FILL is ignored.
- COMMIT (exactly one cycle):
  - cwp<=tgt and done=1.
  - After SPILL: wim rotates right by one (invalid bit moves from tgt to tgt-1).
  - After FILL: wim rotates left by one (invalid bit moves to tgt+1).
  - Then return to IDLE.
- Latency:
  - No trap: cwp updates on the 2nd rising edge after the request edge; done coincides with COMMIT.
  - With trap: 1 + 16 acks + 1 COMMIT cycles minimum.
- Requests and wim_we while busy are ignored (no buffering).
- Rst mid-SPILL/FILL: abort immediately to reset values; the partial transfer is discarded and no done pulse is issued.
- If wim_in makes wim all ones, behaviour is still defined: the next SAVE/RESTORE traps and spills/fills normally.

Test Plan:
- Reset, then RESTORE with no trap: Rst 2 cycles; restore_req 1 cycle -> cwp 0→1, done pulses once, wim stays 4'b1000, trap_unf=0, mem_req never asserted.
- Overflow spill: from reset, save_req -> trap_ovf pulse; 16 mem_req transactions with rf_win=3 and rf_addr 16..31 (ack delayed 0–3 cycles each); then cwp=3, wim=4'b0100, done pulses.
- Underflow fill: wim_we with wim_in=4'b0010 at cwp=0; restore_req -> trap_unf; rf_we pulses exactly 16 times, each in its ack cycle, rf_win=1; final cwp=1, wim=4'b0100.
- Arbitration and wrap: save_req and restore_req together at cwp=0 with wim=0 -> cwp=3 (save wins); next RESTORE -> cwp=0 (wrap).
- Busy masking: during a SPILL, pulse restore_req and wim_we -> both ignored; wim changes only by the COMMIT rotation.
- Reset mid-fill: assert Rst after the 5th ack -> next cycle cwp=0, wim=4'b1000, busy=0, mem_req=0, no done pulse.

Source files
------------

// File: rtl/window_controller.sv
// -----------------------------------------------------------------------------
// window_controller
//
// Sequencer for a windowed register file. Owns the current window pointer
// (CWP) and the window invalid mask (WIM), and executes SAVE / RESTORE
// requests from the decode/control unit. When the target window is marked
// invalid, the controller spills (SAVE) or fills (RESTORE) that window's
// 16 locals/ins (r16..r31) through a request/ack memory handshake before it
// commits the new CWP and rotates the WIM.
//
// Ports
//   Clk          in   clock, rising edge
//   Rst          in   synchronous active-high reset
//   save_req     in   SAVE request (sampled in IDLE only)
//   restore_req  in   RESTORE request (sampled in IDLE only)
//   wim_we       in   load WIM from wim_in (IDLE only, lowest priority)
//   wim_in       in   new WIM value
//   mem_ack      in   memory completed the current transfer
//   cwp          out  current window pointer
//   wim          out  current window invalid mask
//   busy         out  high whenever the sequencer is not IDLE
//   rf_win       out  window being spilled or filled
//   rf_addr      out  register index being moved (16 + idx), 0 otherwise
//   rf_we        out  register file write enable, fill ack cycle only
//   mem_req      out  memory transfer request
//   mem_wr       out  1 = spill (store), 0 = fill (load)
//   trap_ovf     out  one-cycle pulse on overflow detection
//   trap_unf     out  one-cycle pulse on underflow detection
//   done         out  one-cycle pulse while the CWP commits
// -----------------------------------------------------------------------------
module window_controller #(
  parameter int NWIN   = 4,
  parameter int CWP_W  = 2,
  parameter int NSPILL = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             save_req,
  input  logic             restore_req,
  input  logic             wim_we,
  input  logic [NWIN-1:0]  wim_in,
  input  logic             mem_ack,
  output logic [CWP_W-1:0] cwp,
  output logic [NWIN-1:0]  wim,
  output logic             busy,
  output logic [CWP_W-1:0] rf_win,
  output logic [4:0]       rf_addr,
  output logic             rf_we,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             trap_ovf,
  output logic             trap_unf,
  output logic             done
);

  localparam int IDX_W = (NSPILL > 1) ? $clog2(NSPILL) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPILL  = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // How the WIM moves when the pending commit happens.
  typedef enum logic [1:0] {
    ROT_NONE  = 2'd0,
    ROT_RIGHT = 2'd1,
    ROT_LEFT  = 2'd2
  } rot_t;

  state_t           state_q;
  rot_t             rot_q;
  logic [CWP_W-1:0] cwp_q;
  logic [CWP_W-1:0] tgt_q;
  logic [NWIN-1:0]  wim_q;
  logic [IDX_W-1:0] idx_q;
  logic [CWP_W-1:0] rf_win_q;
  logic             mem_req_q;
  logic             mem_wr_q;
  logic             trap_ovf_q;
  logic             trap_unf_q;
  logic             done_q;

  logic [CWP_W-1:0] tgt_save_d;
  logic [CWP_W-1:0] tgt_rest_d;

  // Natural CWP_W-bit wrap gives the modulo-NWIN neighbour windows.
  assign tgt_save_d = cwp_q - CWP_W'(1);
  assign tgt_rest_d = cwp_q + CWP_W'(1);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      rot_q      <= ROT_NONE;
      cwp_q      <= '0;
      tgt_q      <= '0;
      wim_q      <= NWIN'(1) << (NWIN - 1);
      idx_q      <= '0;
      rf_win_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      trap_ovf_q <= 1'b0;
      trap_unf_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      trap_ovf_q <= 1'b0;
      trap_unf_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          // SAVE beats RESTORE; a losing RESTORE is simply dropped.
          if (save_req) begin
            tgt_q <= tgt_save_d;
            if (wim_q[tgt_save_d]) begin
              state_q    <= SPILL;
              rot_q      <= ROT_RIGHT;
              trap_ovf_q <= 1'b1;
              idx_q      <= '0;
              rf_win_q   <= tgt_save_d;
              mem_req_q  <= 1'b1;
              mem_wr_q   <= 1'b1;
            end else begin
              state_q <= COMMIT;
              rot_q   <= ROT_NONE;
              done_q  <= 1'b1;
            end
          end else if (restore_req) begin
            tgt_q <= tgt_rest_d;
            if (wim_q[tgt_rest_d]) begin
              state_q    <= FILL;
              rot_q      <= ROT_LEFT;
              trap_unf_q <= 1'b1;
              idx_q      <= '0;
              rf_win_q   <= tgt_rest_d;
              mem_req_q  <= 1'b1;
              mem_wr_q   <= 1'b0;
            end else begin
              state_q <= COMMIT;
              rot_q   <= ROT_NONE;
              done_q  <= 1'b1;
            end
          end else if (wim_we) begin
            wim_q <= wim_in;
          end
        end

        SPILL, FILL: begin
          if (mem_ack) begin
            if (idx_q == IDX_W'(NSPILL - 1)) begin
              state_q   <= COMMIT;
              done_q    <= 1'b1;
              idx_q     <= '0;
              mem_req_q <= 1'b0;
              mem_wr_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end

        COMMIT: begin
          cwp_q   <= tgt_q;
          state_q <= IDLE;
          rot_q   <= ROT_NONE;
          case (rot_q)
            // After a spill the invalid bit follows the new CWP downwards.
            ROT_RIGHT: wim_q <= {wim_q[0], wim_q[NWIN-1:1]};
            // After a fill the invalid bit moves one window above the new CWP.
            ROT_LEFT:  wim_q <= {wim_q[NWIN-2:0], wim_q[NWIN-1]};
            default:   wim_q <= wim_q;
          endcase
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cwp      = cwp_q;
  assign wim      = wim_q;
  assign busy     = (state_q != IDLE);
  assign rf_win   = rf_win_q;
  assign rf_addr  = ((state_q == SPILL) || (state_q == FILL)) ? (5'd16 + 5'(idx_q)) : 5'd0;
  // Fill data is written into the register file in the very cycle memory acks it.
  assign rf_we    = (state_q == FILL) && mem_ack;
  assign mem_req  = mem_req_q;
  assign mem_wr   = mem_wr_q;
  assign trap_ovf = trap_ovf_q;
  assign trap_unf = trap_unf_q;
  assign done     = done_q;

endmodule

// File: tb/tb_window_controller.sv
module tb_window_controller;

  logic       Clk;
  logic       Rst;
  logic       save_req;
  logic       restore_req;
  logic       wim_we;
  logic [3:0] wim_in;
  logic       mem_ack;
  logic [1:0] cwp;
  logic [3:0] wim;
  logic       busy;
  logic [1:0] rf_win;
  logic [4:0] rf_addr;
  logic       rf_we;
  logic       mem_req;
  logic       mem_wr;
  logic       trap_ovf;
  logic       trap_unf;
  logic       done;

  int n_cmp;
  int n_err;
  int rf_we_cnt;

  window_controller #(.NWIN(4), .CWP_W(2), .NSPILL(16)) dut (
    .Clk(Clk), .Rst(Rst), .save_req(save_req), .restore_req(restore_req),
    .wim_we(wim_we), .wim_in(wim_in), .mem_ack(mem_ack),
    .cwp(cwp), .wim(wim), .busy(busy), .rf_win(rf_win), .rf_addr(rf_addr),
    .rf_we(rf_we), .mem_req(mem_req), .mem_wr(mem_wr),
    .trap_ovf(trap_ovf), .trap_unf(trap_unf), .done(done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       rst;
    logic       sv;
    logic       rs;
    logic       we;
    logic [3:0] win;
    logic       ack;
    logic [1:0] cwp;
    logic [3:0] wim;
    logic       busy;
    logic       done;
    logic       tovf;
    logic       tunf;
    logic       mreq;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Rst = 1'b0; save_req = 1'b0; restore_req = 1'b0;
    wim_we = 1'b0; wim_in = 4'h0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  // Runs nacks transfers; ack for transfer k arrives after k%4 wait cycles.
  // With inject set, restore_req and wim_we (all ones) are pulsed in a wait cycle.
  task automatic run_xfer(input bit fill, input int nacks, input bit inject,
                          input logic [1:0] exp_win, input logic [3:0] exp_wim);
    bit first;
    first = 1'b1;
    for (int k = 0; k < nacks; k++) begin
      for (int j = 0; j < (k % 4); j++) begin
        mem_ack = 1'b0;
        if (inject && k == 2 && j == 0) begin
          restore_req = 1'b1; wim_we = 1'b1; wim_in = 4'hF;
        end
        #1;
        chk("xfer_wait_mem_req", 32'(mem_req), 32'd1);
        chk("xfer_wait_rf_addr", 32'(rf_addr), 32'(16 + k));
        chk("xfer_wait_rf_we", 32'(rf_we), 32'd0);
        chk("xfer_wait_wim", 32'(wim), 32'(exp_wim));
        if (!first) chk("xfer_trap_clear", 32'({trap_ovf, trap_unf}), 32'd0);
        first = 1'b0;
        if (rf_we) rf_we_cnt++;
        tick();
        restore_req = 1'b0; wim_we = 1'b0; wim_in = 4'h0;
      end
      mem_ack = 1'b1;
      #1;
      chk("xfer_ack_mem_req", 32'(mem_req), 32'd1);
      chk("xfer_ack_mem_wr", 32'(mem_wr), fill ? 32'd0 : 32'd1);
      chk("xfer_ack_rf_addr", 32'(rf_addr), 32'(16 + k));
      chk("xfer_ack_rf_win", 32'(rf_win), 32'(exp_win));
      chk("xfer_ack_rf_we", 32'(rf_we), fill ? 32'd1 : 32'd0);
      chk("xfer_ack_busy", 32'(busy), 32'd1);
      if (!first) chk("xfer_trap_clear", 32'({trap_ovf, trap_unf}), 32'd0);
      first = 1'b0;
      if (rf_we) rf_we_cnt++;
      tick();
      mem_ack = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_inputs();

    //          rst   sv    rs    we    win   ack   cwp   wim   busy  done  tovf  tunf  mreq
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd3, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 1'b0, 2'd3, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd3, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    #1;
    for (int i = 0; i < NVEC; i++) begin
      Rst = tbl[i].rst; save_req = tbl[i].sv; restore_req = tbl[i].rs;
      wim_we = tbl[i].we; wim_in = tbl[i].win; mem_ack = tbl[i].ack;
      tick();
      chk($sformatf("vec%0d_cwp", i), 32'(cwp), 32'(tbl[i].cwp));
      chk($sformatf("vec%0d_wim", i), 32'(wim), 32'(tbl[i].wim));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("vec%0d_trap_ovf", i), 32'(trap_ovf), 32'(tbl[i].tovf));
      chk($sformatf("vec%0d_trap_unf", i), 32'(trap_unf), 32'(tbl[i].tunf));
      chk($sformatf("vec%0d_mem_req", i), 32'(mem_req), 32'(tbl[i].mreq));
      chk($sformatf("vec%0d_rf_addr", i), 32'(rf_addr), 32'd0);
    end
    idle_inputs();

    // Overflow spill from reset: window 3 is invalid.
    do_reset();
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    chk("ovf_trap_ovf", 32'(trap_ovf), 32'd1);
    chk("ovf_trap_unf", 32'(trap_unf), 32'd0);
    chk("ovf_mem_req", 32'(mem_req), 32'd1);
    chk("ovf_rf_win", 32'(rf_win), 32'd3);
    chk("ovf_cwp_hold", 32'(cwp), 32'd0);
    rf_we_cnt = 0;
    run_xfer(1'b0, 16, 1'b0, 2'd3, 4'h8);
    chk("ovf_rf_we_cnt", 32'(rf_we_cnt), 32'd0);
    chk("ovf_done", 32'(done), 32'd1);
    chk("ovf_mem_req_off", 32'(mem_req), 32'd0);
    chk("ovf_cwp_pre", 32'(cwp), 32'd0);
    tick();
    chk("ovf_cwp", 32'(cwp), 32'd3);
    chk("ovf_wim", 32'(wim), 32'h4);
    chk("ovf_done_off", 32'(done), 32'd0);
    chk("ovf_busy_off", 32'(busy), 32'd0);

    // Underflow fill: WIM=0010 at cwp 0, RESTORE targets window 1.
    do_reset();
    wim_we = 1'b1; wim_in = 4'h2;
    tick();
    wim_we = 1'b0; wim_in = 4'h0;
    chk("unf_wim_load", 32'(wim), 32'h2);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    chk("unf_trap_unf", 32'(trap_unf), 32'd1);
    chk("unf_trap_ovf", 32'(trap_ovf), 32'd0);
    chk("unf_mem_wr", 32'(mem_wr), 32'd0);
    chk("unf_rf_win", 32'(rf_win), 32'd1);
    rf_we_cnt = 0;
    run_xfer(1'b1, 16, 1'b0, 2'd1, 4'h2);
    chk("unf_rf_we_cnt", 32'(rf_we_cnt), 32'd16);
    chk("unf_done", 32'(done), 32'd1);
    tick();
    chk("unf_cwp", 32'(cwp), 32'd1);
    chk("unf_wim", 32'(wim), 32'h4);
    chk("unf_done_off", 32'(done), 32'd0);

    // Busy masking: restore_req and wim_we pulsed mid-spill are ignored.
    do_reset();
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    run_xfer(1'b0, 16, 1'b1, 2'd3, 4'h8);
    tick();
    chk("mask_cwp", 32'(cwp), 32'd3);
    chk("mask_wim", 32'(wim), 32'h4);
    chk("mask_busy", 32'(busy), 32'd0);

    // Reset after the 5th fill ack aborts the fill.
    do_reset();
    wim_we = 1'b1; wim_in = 4'h2;
    tick();
    wim_we = 1'b0; wim_in = 4'h0;
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    run_xfer(1'b1, 5, 1'b0, 2'd1, 4'h2);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("rst_fill_cwp", 32'(cwp), 32'd0);
    chk("rst_fill_wim", 32'(wim), 32'h8);
    chk("rst_fill_busy", 32'(busy), 32'd0);
    chk("rst_fill_mem_req", 32'(mem_req), 32'd0);
    chk("rst_fill_done", 32'(done), 32'd0);
    chk("rst_fill_rf_win", 32'(rf_win), 32'd0);
    tick();
    chk("rst_fill_done_after", 32'(done), 32'd0);
    chk("rst_fill_busy_after", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
